// File: rtl/vt_engine.sv
// vt_engine: byte-stream terminal engine. Parses printable bytes, control
// characters and a small CSI subset, then issues cell writes to VRAM through a
// valid/ready channel. The screen is a circular window of SCREEN_ROWS rows
// inside VRAM_ROWS physical rows, and scrolling moves top_row.
module vt_engine #(
  parameter int COLS        = 100,
  parameter int SCREEN_ROWS = 30,
  parameter int VRAM_ROWS   = 32,
  parameter int TAB_WIDTH   = 8,
  localparam int RW = $clog2(VRAM_ROWS),
  localparam int CW = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          host_ready,
  input  logic          host_valid,
  input  logic [7:0]    host_byte,
  input  logic          vram_ready,
  output logic          vram_valid,
  output logic [RW-1:0] vram_row,
  output logic [CW-1:0] vram_col,
  output logic [7:0]    vram_byte,
  output logic [RW-1:0] top_row,
  output logic [RW-1:0] cursor_row,
  output logic [CW-1:0] cursor_col
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ESC,
    S_CSI,
    S_DISPLAY,
    S_SCROLL,
    S_CLEAR
  } state_t;

  localparam logic [7:0] CH_BS    = 8'd8;
  localparam logic [7:0] CH_TAB   = 8'd9;
  localparam logic [7:0] CH_LF    = 8'd10;
  localparam logic [7:0] CH_CR    = 8'd13;
  localparam logic [7:0] CH_ESC   = 8'd27;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LBRK  = 8'h5B;
  localparam logic [7:0] CH_A     = 8'h41;
  localparam logic [7:0] CH_B     = 8'h42;
  localparam logic [7:0] CH_C     = 8'h43;
  localparam logic [7:0] CH_D     = 8'h44;
  localparam logic [7:0] CH_J     = 8'h4A;
  localparam logic [7:0] CH_K     = 8'h4B;

  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_SPAN  = RW'(SCREEN_ROWS - 1);

  state_t        state, state_n;
  logic [RW-1:0] top_row_n, cursor_row_n;
  logic [CW-1:0] cursor_col_n;
  logic [6:0]    param, param_n;
  logic          seen, seen_n;
  logic [7:0]    char_q, char_n;
  logic [RW-1:0] wr_row, wr_row_n;
  logic [CW-1:0] wr_col, wr_col_n;
  logic [RW-1:0] rows_left, rows_left_n;
  logic          clr_home, clr_home_n;
  logic          do_lf;

  logic          host_fire, vram_fire;
  logic [RW-1:0] bottom;
  logic [6:0]    n_val;
  logic [31:0]   n32;
  logic [RW-1:0] dist_up, dist_down;
  logic [RW-1:0] up_row, down_row;
  logic [31:0]   col_sum, tab_next, digit_sum;
  logic [CW-1:0] right_col, left_col, tab_col;
  logic [6:0]    digit_param;
  logic          is_digit;

  assign host_ready = (state == S_IDLE) || (state == S_ESC) || (state == S_CSI);
  assign host_fire  = host_valid && host_ready;
  assign vram_fire  = vram_valid && vram_ready;
  assign bottom     = top_row + ROW_SPAN;

  // Cursor-move candidates; distances wrap modulo VRAM_ROWS so clamping works
  // across the physical wrap point.
  assign n_val     = (seen && (param != '0)) ? param : 7'd1;
  assign n32       = 32'(n_val);
  assign dist_up   = cursor_row - top_row;
  assign dist_down = bottom - cursor_row;
  assign up_row    = (n32 >= 32'(dist_up))   ? top_row : cursor_row - RW'(n_val);
  assign down_row  = (n32 >= 32'(dist_down)) ? bottom  : cursor_row + RW'(n_val);
  assign col_sum   = 32'(cursor_col) + n32;
  assign right_col = (col_sum > 32'(COLS - 1)) ? LAST_COL : CW'(col_sum);
  assign left_col  = (n32 >= 32'(cursor_col)) ? '0 : cursor_col - CW'(n_val);
  assign tab_next  = (32'(cursor_col) / 32'(TAB_WIDTH) + 32'd1) * 32'(TAB_WIDTH);
  assign tab_col   = (tab_next > 32'(COLS - 1)) ? LAST_COL : CW'(tab_next);
  assign is_digit  = (host_byte >= 8'h30) && (host_byte <= 8'h39);
  assign digit_sum = 32'(param) * 32'd10 + 32'(host_byte - 8'h30);
  assign digit_param = (digit_sum > 32'd99) ? 7'd99 : 7'(digit_sum);

  // VRAM channel driven purely from registered state so it holds while stalled.
  always_comb begin
    vram_valid = 1'b0;
    vram_row   = cursor_row;
    vram_col   = cursor_col;
    vram_byte  = CH_SPACE;
    case (state)
      S_DISPLAY: begin
        vram_valid = 1'b1;
        vram_byte  = char_q;
      end
      S_SCROLL: begin
        vram_valid = 1'b1;
        vram_col   = wr_col;
      end
      S_CLEAR: begin
        vram_valid = 1'b1;
        vram_row   = wr_row;
        vram_col   = wr_col;
      end
      default: ;
    endcase
  end

  // Next-state and datapath updates for the parser and write sequencers.
  always_comb begin
    state_n      = state;
    top_row_n    = top_row;
    cursor_row_n = cursor_row;
    cursor_col_n = cursor_col;
    param_n      = param;
    seen_n       = seen;
    char_n       = char_q;
    wr_row_n     = wr_row;
    wr_col_n     = wr_col;
    rows_left_n  = rows_left;
    clr_home_n   = clr_home;
    do_lf        = 1'b0;

    case (state)
      S_IDLE: begin
        if (host_fire) begin
          case (host_byte)
            CH_BS:  if (cursor_col != '0) cursor_col_n = cursor_col - 1'b1;
            CH_CR:  cursor_col_n = '0;
            CH_LF:  do_lf = 1'b1;
            CH_TAB: cursor_col_n = tab_col;
            CH_ESC: state_n = S_ESC;
            default: begin
              char_n  = host_byte;
              state_n = S_DISPLAY;
            end
          endcase
        end
      end

      S_ESC: begin
        if (host_fire) begin
          if (host_byte == CH_LBRK) begin
            param_n = '0;
            seen_n  = 1'b0;
            state_n = S_CSI;
          end else begin
            state_n = S_IDLE;
          end
        end
      end

      S_CSI: begin
        if (host_fire) begin
          if (is_digit) begin
            param_n = digit_param;
            seen_n  = 1'b1;
          end else begin
            state_n = S_IDLE;
            case (host_byte)
              CH_A: cursor_row_n = up_row;
              CH_B: cursor_row_n = down_row;
              CH_C: cursor_col_n = right_col;
              CH_D: cursor_col_n = left_col;
              CH_K: begin
                wr_row_n    = cursor_row;
                wr_col_n    = cursor_col;
                rows_left_n = '0;
                clr_home_n  = 1'b0;
                state_n     = S_CLEAR;
              end
              CH_J: begin
                if (param == 7'd2) begin
                  wr_row_n    = top_row;
                  wr_col_n    = '0;
                  rows_left_n = ROW_SPAN;
                  clr_home_n  = 1'b1;
                  state_n     = S_CLEAR;
                end
              end
              default: ;
            endcase
          end
        end
      end

      S_DISPLAY: begin
        if (vram_fire) begin
          if (cursor_col < LAST_COL) begin
            cursor_col_n = cursor_col + 1'b1;
            state_n      = S_IDLE;
          end else begin
            cursor_col_n = '0;
            do_lf        = 1'b1;
          end
        end
      end

      S_SCROLL: begin
        if (vram_fire) begin
          if (wr_col == LAST_COL) state_n = S_IDLE;
          else                    wr_col_n = wr_col + 1'b1;
        end
      end

      S_CLEAR: begin
        if (vram_fire) begin
          if (wr_col == LAST_COL) begin
            if (rows_left == '0) begin
              state_n = S_IDLE;
              if (clr_home) begin
                cursor_row_n = top_row;
                cursor_col_n = '0;
              end
            end else begin
              wr_row_n    = wr_row + 1'b1;
              wr_col_n    = '0;
              rows_left_n = rows_left - 1'b1;
            end
          end else begin
            wr_col_n = wr_col + 1'b1;
          end
        end
      end

      default: state_n = S_IDLE;
    endcase

    // Shared line-feed path used by LF and by printing past the last column.
    if (do_lf) begin
      cursor_row_n = cursor_row + 1'b1;
      if (cursor_row != bottom) begin
        state_n = S_IDLE;
      end else begin
        top_row_n = top_row + 1'b1;
        wr_col_n  = '0;
        state_n   = S_SCROLL;
      end
    end
  end

  // State register; reset overrides any same-cycle update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      top_row    <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      param      <= '0;
      seen       <= 1'b0;
      char_q     <= '0;
      wr_row     <= '0;
      wr_col     <= '0;
      rows_left  <= '0;
      clr_home   <= 1'b0;
    end else begin
      state      <= state_n;
      top_row    <= top_row_n;
      cursor_row <= cursor_row_n;
      cursor_col <= cursor_col_n;
      param      <= param_n;
      seen       <= seen_n;
      char_q     <= char_n;
      wr_row     <= wr_row_n;
      wr_col     <= wr_col_n;
      rows_left  <= rows_left_n;
      clr_home   <= clr_home_n;
    end
  end

endmodule

// File: tb/tb_vt_engine.sv
// Directed self-checking bench for vt_engine with default parameters.
module tb_vt_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       host_ready;
  logic       host_valid = 1'b0;
  logic [7:0] host_byte = '0;
  logic       vram_ready = 1'b1;
  logic       vram_valid;
  logic [4:0] vram_row;
  logic [6:0] vram_col;
  logic [7:0] vram_byte;
  logic [4:0] top_row;
  logic [4:0] cursor_row;
  logic [6:0] cursor_col;

  int checks = 0;
  int failures = 0;

  // Completed writes recorded by the monitor.
  logic [4:0] wq_row[$];
  logic [6:0] wq_col[$];
  logic [7:0] wq_byte[$];
  int         stall_err = 0;
  logic       stall_pend = 1'b0;
  logic [4:0] s_row;
  logic [6:0] s_col;
  logic [7:0] s_byte;

  vt_engine #(.COLS(100), .SCREEN_ROWS(30), .VRAM_ROWS(32), .TAB_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .host_ready(host_ready), .host_valid(host_valid), .host_byte(host_byte),
    .vram_ready(vram_ready), .vram_valid(vram_valid), .vram_row(vram_row),
    .vram_col(vram_col), .vram_byte(vram_byte),
    .top_row(top_row), .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  always #5 clk = ~clk;

  // Record handshakes and flag any change on a stalled write.
  always @(posedge clk) begin
    if (vram_valid && vram_ready) begin
      wq_row.push_back(vram_row);
      wq_col.push_back(vram_col);
      wq_byte.push_back(vram_byte);
    end
    if (stall_pend && (vram_valid !== 1'b1 || vram_row !== s_row ||
                       vram_col !== s_col || vram_byte !== s_byte))
      stall_err <= stall_err + 1;
    stall_pend <= vram_valid && !vram_ready && !reset;
    s_row  <= vram_row;
    s_col  <= vram_col;
    s_byte <= vram_byte;
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (!host_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      checks++; failures++;
      $display("FAIL send_timeout: host_ready stayed %b, required 1", host_ready);
    end
    host_valid = 1'b1;
    host_byte  = b;
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic csi(input string s);
    send_byte(8'h1b);
    send_byte(8'h5b);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((!host_ready || vram_valid) && t < 10000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 10000) begin
      checks++; failures++;
      $display("FAIL %s_timeout: host_ready=%b vram_valid=%b, required 1/0", name, host_ready, vram_valid);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_cursor(input string name, input logic [4:0] er, input logic [6:0] ec);
    checks++;
    if (cursor_row !== er || cursor_col !== ec) begin
      failures++;
      $display("FAIL %s: cursor=(%0d,%0d) required (%0d,%0d)", name, cursor_row, cursor_col, er, ec);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (host_ready !== 1'b1 || vram_valid !== 1'b0 || top_row !== 5'd0 ||
        cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      failures++;
      $display("FAIL reset_state: hr=%b vv=%b top=%0d cur=(%0d,%0d) required 1 0 0 (0,0)",
               host_ready, vram_valid, top_row, cursor_row, cursor_col);
    end
  endtask

  task automatic test_print_a();
    int start = wq_row.size();
    @(negedge clk);
    host_valid = 1'b1;
    host_byte  = 8'h41;
    @(negedge clk);
    host_valid = 1'b0;
    checks++;
    if (host_ready !== 1'b0 || vram_valid !== 1'b1 || vram_row !== 5'd0 ||
        vram_col !== 7'd0 || vram_byte !== 8'h41) begin
      failures++;
      $display("FAIL print_a_write: hr=%b vv=%b (%0d,%0d,%h) required 0 1 (0,0,41)",
               host_ready, vram_valid, vram_row, vram_col, vram_byte);
    end
    @(negedge clk);
    checks++;
    if (host_ready !== 1'b1 || cursor_col !== 7'd1 || wq_row.size() - start != 1) begin
      failures++;
      $display("FAIL print_a_done: hr=%b col=%0d writes=%0d required 1 1 1",
               host_ready, cursor_col, wq_row.size() - start);
    end
  endtask

  task automatic test_cursor_moves();
    int start = wq_row.size();
    send_byte(8'h0d); csi("5C");   check_cursor("csi_c5", 5'd0, 7'd5);
    send_byte(8'h09);              check_cursor("tab_5", 5'd0, 7'd8);
    send_byte(8'h09);              check_cursor("tab_8", 5'd0, 7'd16);
    send_byte(8'h0d); csi("97C");  check_cursor("csi_c97", 5'd0, 7'd97);
    send_byte(8'h09);              check_cursor("tab_97", 5'd0, 7'd99);
    send_byte(8'h08);              check_cursor("bs_99", 5'd0, 7'd98);
    send_byte(8'h0d); send_byte(8'h08); check_cursor("bs_0", 5'd0, 7'd0);
    csi("123C");                   check_cursor("csi_c_sat", 5'd0, 7'd99);
    csi("D");                      check_cursor("csi_d1", 5'd0, 7'd98);
    csi("200D");                   check_cursor("csi_d_clamp", 5'd0, 7'd0);
    csi("3B");                     check_cursor("csi_b3", 5'd3, 7'd0);
    csi("A");                      check_cursor("csi_a1", 5'd2, 7'd0);
    csi("0A");                     check_cursor("csi_a0", 5'd1, 7'd0);
    csi("50A");                    check_cursor("csi_a_clamp", 5'd0, 7'd0);
    csi("99B");                    check_cursor("csi_b_clamp", 5'd29, 7'd0);
    csi("5Z");                     check_cursor("csi_unknown", 5'd29, 7'd0);
    send_byte(8'h1b); send_byte(8'h78); check_cursor("esc_other", 5'd29, 7'd0);
    checks++;
    if (wq_row.size() != start || top_row !== 5'd0) begin
      failures++;
      $display("FAIL moves_no_write: writes=%0d top=%0d required 0 0", wq_row.size() - start, top_row);
    end
    send_byte(8'h51);
    wait_idle("print_q");
    checks++;
    if (wq_row.size() != start + 1 || wq_row[start] !== 5'd29 || wq_col[start] !== 7'd0 ||
        wq_byte[start] !== 8'h51 || cursor_col !== 7'd1) begin
      failures++;
      $display("FAIL print_q: writes=%0d col=%0d required 1 write (29,0,51) col 1",
               wq_row.size() - start, cursor_col);
    end
  endtask

  task automatic test_wrap_scroll();
    int start;
    int bad = 0;
    do_reset();
    csi("29B");
    csi("99C");
    check_cursor("pos_29_99", 5'd29, 7'd99);
    start = wq_row.size();
    send_byte(8'h78);
    wait_idle("wrap_scroll");
    checks++;
    if (top_row !== 5'd1 || cursor_row !== 5'd30 || cursor_col !== 7'd0) begin
      failures++;
      $display("FAIL wrap_state: top=%0d cur=(%0d,%0d) required 1 (30,0)", top_row, cursor_row, cursor_col);
    end
    checks++;
    if (wq_row.size() - start != 101) begin
      failures++;
      $display("FAIL wrap_count: writes=%0d required 101", wq_row.size() - start);
    end else begin
      if (wq_row[start] !== 5'd29 || wq_col[start] !== 7'd99 || wq_byte[start] !== 8'h78) bad++;
      for (int i = 0; i < 100; i++)
        if (wq_row[start+1+i] !== 5'd30 || wq_col[start+1+i] !== 7'(i) || wq_byte[start+1+i] !== 8'h20) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL wrap_order: %0d bad writes, required 0", bad);
      end
    end
  endtask

  task automatic test_wrap_modulo();
    int start;
    int bad = 0;
    for (int i = 0; i < 30; i++) begin
      send_byte(8'h0a);
      wait_idle("lf_scroll");
    end
    checks++;
    if (top_row !== 5'd31 || cursor_row !== 5'd28) begin
      failures++;
      $display("FAIL lf_top31: top=%0d row=%0d required 31 28", top_row, cursor_row);
    end
    start = wq_row.size();
    send_byte(8'h0a);
    wait_idle("lf_wrap");
    checks++;
    if (top_row !== 5'd0 || cursor_row !== 5'd29) begin
      failures++;
      $display("FAIL lf_wrap: top=%0d row=%0d required 0 29", top_row, cursor_row);
    end
    checks++;
    if (wq_row.size() - start != 100) begin
      failures++;
      $display("FAIL lf_wrap_count: writes=%0d required 100", wq_row.size() - start);
    end else begin
      for (int i = 0; i < 100; i++)
        if (wq_row[start+i] !== 5'd29 || wq_col[start+i] !== 7'(i) || wq_byte[start+i] !== 8'h20) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL lf_wrap_order: %0d bad writes, required 0", bad);
      end
    end
  endtask

  task automatic test_clear_screen();
    int start;
    int serr0;
    int t = 0;
    int bad = 0;
    logic [4:0] er;
    csi("7C");
    check_cursor("pre_clear", 5'd29, 7'd7);
    serr0 = stall_err;
    start = wq_row.size();
    vram_ready = 1'b0;
    csi("2J");
    while ((!host_ready || vram_valid) && t < 20000) begin
      vram_ready = ~vram_ready;
      @(negedge clk);
      t++;
    end
    vram_ready = 1'b1;
    checks++;
    if (t >= 20000 || wq_row.size() - start != 3000) begin
      failures++;
      $display("FAIL clear_count: writes=%0d cycles=%0d required 3000 writes", wq_row.size() - start, t);
    end else begin
      for (int i = 0; i < 3000; i++) begin
        er = 5'(i / 100);
        if (wq_row[start+i] !== er || wq_col[start+i] !== 7'(i % 100) || wq_byte[start+i] !== 8'h20) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL clear_order: %0d bad writes, required 0", bad);
      end
    end
    checks++;
    if (stall_err != serr0) begin
      failures++;
      $display("FAIL clear_stable: %0d unstable stalled cycles, required 0", stall_err - serr0);
    end
    check_cursor("clear_home", 5'd0, 7'd0);
  endtask

  task automatic test_reset_mid_clear();
    int start;
    int t = 0;
    int bad = 0;
    vram_ready = 1'b1;
    csi("5B");
    csi("40C");
    check_cursor("pre_k", 5'd5, 7'd40);
    start = wq_row.size();
    csi("K");
    while (wq_row.size() - start < 10 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    vram_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vram_ready = 1'b1;
    checks++;
    if (host_ready !== 1'b1 || vram_valid !== 1'b0 || top_row !== 5'd0 ||
        cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
      failures++;
      $display("FAIL midk_reset: hr=%b vv=%b top=%0d cur=(%0d,%0d) required 1 0 0 (0,0)",
               host_ready, vram_valid, top_row, cursor_row, cursor_col);
    end
    repeat (120) @(negedge clk);
    checks++;
    if (wq_row.size() - start != 10) begin
      failures++;
      $display("FAIL midk_count: writes=%0d required 10", wq_row.size() - start);
    end else begin
      for (int i = 0; i < 10; i++)
        if (wq_row[start+i] !== 5'd5 || wq_col[start+i] !== 7'(40 + i) || wq_byte[start+i] !== 8'h20) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL midk_order: %0d bad writes, required 0", bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_print_a();
    test_cursor_moves();
    test_wrap_scroll();
    test_wrap_modulo();
    test_clear_screen();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
